game_round_controller: RTL and testbench

Downstream consumer of the access controller's Logged_In output. It runs the binary mental-math game only while a user is logged in. Each round it draws two 4-bit operands from a free-running LFSR and presents them for display. It then accepts the player's 5-bit binary sum, checks it against the true sum, enforces a per-round time limit, and keeps the score across a fixed number of rounds.

---
 rtl/game_round_controller.sv | 213 +++++++++++++++++++++
 tb/tb_game_round_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_controller.sv
// game_round_controller
//
// Runs the binary mental-math game while a user is logged in. Each round two
// 4-bit operands are drawn from a free-running 8-bit LFSR and presented. The
// player then enters a 5-bit binary sum, which is checked against the true
// sum under a per-round time limit. The score is kept over NUM_ROUNDS rounds.
//
// Ports:
//   clk            : system clock
//   rst            : synchronous active-high reset
//   Logged_In      : level from the access controller; the game runs only while high
//   Start          : single-cycle pulse that begins a new game (IDLE or DONE only)
//   Answer_Enter   : single-cycle pulse; Answer is valid this cycle (ASK only)
//   Answer         : player's 5-bit binary sum
//   Operand_A/B    : operands of the current question
//   Question_Valid : high while a question awaits an answer
//   Correct        : one-cycle pulse, the answer was right
//   Wrong          : one-cycle pulse, the answer was wrong
//   Timeout        : one-cycle pulse, the round time expired
//   Score          : correct answers in the current or last game
//   Round          : current round number, 1-based; 0 before the first round
//   Game_Over      : high after the final round, until the next Start or logout

module game_round_controller #(
  parameter int         ROUND_TIME = 1000,
  parameter int         NUM_ROUNDS = 8,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Logged_In,
  input  logic       Start,
  input  logic       Answer_Enter,
  input  logic [4:0] Answer,
  output logic [3:0] Operand_A,
  output logic [3:0] Operand_B,
  output logic       Question_Valid,
  output logic       Correct,
  output logic       Wrong,
  output logic       Timeout,
  output logic [3:0] Score,
  output logic [3:0] Round,
  output logic       Game_Over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ASK,
    S_RESULT,
    S_DONE
  } state_t;

  localparam logic [15:0] TIMER_LOAD = 16'(ROUND_TIME - 1);
  localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  op_a_q, op_a_d;
  logic [3:0]  op_b_q, op_b_d;
  logic        qv_q, qv_d;
  logic        correct_q, correct_d;
  logic        wrong_q, wrong_d;
  logic        timeout_q, timeout_d;
  logic [3:0]  score_q, score_d;
  logic [3:0]  round_q, round_d;
  logic        game_over_q, game_over_d;
  logic [4:0]  true_sum;

  // Zero-extended so that a carry out of the 4-bit add is kept.
  assign true_sum = {1'b0, op_a_q} + {1'b0, op_b_q};

  // Next-state logic. The result pulses default low so they can only be high
  // for the single RESULT cycle. Question_Valid and Game_Over are computed one
  // cycle ahead so that the registered copies line up with the state.
  always_comb begin
    state_d     = state_q;
    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; free-running in every state.
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    timer_d     = timer_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    qv_d        = qv_q;
    correct_d   = 1'b0;
    wrong_d     = 1'b0;
    timeout_d   = 1'b0;
    score_d     = score_q;
    round_d     = round_q;
    game_over_d = game_over_q;

    case (state_q)
      S_IDLE: begin
        qv_d        = 1'b0;
        game_over_d = 1'b0;
        if (Start && Logged_In) begin
          state_d = S_LOAD;
          score_d = 4'd0;
          round_d = 4'd0;
        end
      end

      S_LOAD: begin
        if (!Logged_In) begin
          state_d = S_IDLE;
          qv_d    = 1'b0;
        end else begin
          op_a_d  = lfsr_q[7:4];
          op_b_d  = lfsr_q[3:0];
          round_d = round_q + 4'd1;
          timer_d = TIMER_LOAD;
          qv_d    = 1'b1;
          state_d = S_ASK;
        end
      end

      // Logout beats an answer, and an answer beats an expiring timer.
      S_ASK: begin
        if (!Logged_In) begin
          state_d = S_IDLE;
          qv_d    = 1'b0;
        end else if (Answer_Enter) begin
          if (Answer == true_sum) begin
            correct_d = 1'b1;
            score_d   = score_q + 4'd1;
          end else begin
            wrong_d = 1'b1;
          end
          qv_d    = 1'b0;
          state_d = S_RESULT;
        end else if (timer_q == 16'd0) begin
          timeout_d = 1'b1;
          qv_d      = 1'b0;
          state_d   = S_RESULT;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      S_RESULT: begin
        qv_d = 1'b0;
        if (!Logged_In) begin
          state_d = S_IDLE;
        end else if (round_q == LAST_ROUND) begin
          game_over_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end

      S_DONE: begin
        if (!Logged_In) begin
          game_over_d = 1'b0;
          state_d     = S_IDLE;
        end else if (Start) begin
          game_over_d = 1'b0;
          score_d     = 4'd0;
          round_d     = 4'd0;
          state_d     = S_LOAD;
        end
      end

      default: begin
        state_d     = S_IDLE;
        qv_d        = 1'b0;
        game_over_d = 1'b0;
      end
    endcase
  end

  // All state and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      timer_q     <= 16'd0;
      op_a_q      <= 4'd0;
      op_b_q      <= 4'd0;
      qv_q        <= 1'b0;
      correct_q   <= 1'b0;
      wrong_q     <= 1'b0;
      timeout_q   <= 1'b0;
      score_q     <= 4'd0;
      round_q     <= 4'd0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      timer_q     <= timer_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      qv_q        <= qv_d;
      correct_q   <= correct_d;
      wrong_q     <= wrong_d;
      timeout_q   <= timeout_d;
      score_q     <= score_d;
      round_q     <= round_d;
      game_over_q <= game_over_d;
    end
  end

  assign Operand_A      = op_a_q;
  assign Operand_B      = op_b_q;
  assign Question_Valid = qv_q;
  assign Correct        = correct_q;
  assign Wrong          = wrong_q;
  assign Timeout        = timeout_q;
  assign Score          = score_q;
  assign Round          = round_q;
  assign Game_Over      = game_over_q;

endmodule

// File: tb/tb_game_round_controller.sv
// tb_game_round_controller
//
// Directed testbench for game_round_controller with ROUND_TIME=10 and
// NUM_ROUNDS=3. Inputs change 1 time unit after the rising edge, and outputs
// are sampled at that same point. An independent LFSR model, written from the
// x^8+x^6+x^5+x^4+1 polynomial, supplies the expected operands.

module tb_game_round_controller;

  logic       clk;
  logic       rst;
  logic       Logged_In;
  logic       Start;
  logic       Answer_Enter;
  logic [4:0] Answer;
  logic [3:0] Operand_A;
  logic [3:0] Operand_B;
  logic       Question_Valid;
  logic       Correct;
  logic       Wrong;
  logic       Timeout;
  logic [3:0] Score;
  logic [3:0] Round;
  logic       Game_Over;

  int vectorCount;
  int missCount;
  int askCycles;
  logic [7:0] lfsrModel;
  logic [7:0] lfsrPrev;
  logic [4:0] expSum;

  game_round_controller #(
    .ROUND_TIME(10),
    .NUM_ROUNDS(3),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Logged_In     (Logged_In),
    .Start         (Start),
    .Answer_Enter  (Answer_Enter),
    .Answer        (Answer),
    .Operand_A     (Operand_A),
    .Operand_B     (Operand_B),
    .Question_Valid(Question_Valid),
    .Correct       (Correct),
    .Wrong         (Wrong),
    .Timeout       (Timeout),
    .Score         (Score),
    .Round         (Round),
    .Game_Over     (Game_Over)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR. lfsrPrev holds last cycle's value, which is what LOAD
  // captured by the time the first ASK cycle is observed.
  always @(posedge clk) begin
    if (rst) lfsrModel <= 8'hA5;
    else     lfsrModel <= {lfsrModel[6:0], lfsrModel[7] ^ lfsrModel[5] ^ lfsrModel[4] ^ lfsrModel[3]};
    lfsrPrev <= lfsrModel;
  end

  // Single comparison point: counts every vector and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Present one cycle of pulse inputs, then release them after the edge.
  task automatic applyStimulus(input logic s, input logic ae, input logic [4:0] ans);
    Start        = s;
    Answer_Enter = ae;
    Answer       = ans;
    @(posedge clk);
    #1;
    Start        = 1'b0;
    Answer_Enter = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_opa"}, 16'(Operand_A), 16'd0);
    checkOutput({tag, "_opb"}, 16'(Operand_B), 16'd0);
    checkOutput({tag, "_qv"}, 16'(Question_Valid), 16'd0);
    checkOutput({tag, "_cor"}, 16'(Correct), 16'd0);
    checkOutput({tag, "_wr"}, 16'(Wrong), 16'd0);
    checkOutput({tag, "_to"}, 16'(Timeout), 16'd0);
    checkOutput({tag, "_score"}, 16'(Score), 16'd0);
    checkOutput({tag, "_round"}, 16'(Round), 16'd0);
    checkOutput({tag, "_go"}, 16'(Game_Over), 16'd0);
  endtask

  // Called in the first ASK cycle of a round.
  task automatic checkOperands(input string tag);
    checkOutput({tag, "_opa"}, 16'(Operand_A), 16'(lfsrPrev[7:4]));
    checkOutput({tag, "_opb"}, 16'(Operand_B), 16'(lfsrPrev[3:0]));
    expSum = {1'b0, lfsrPrev[7:4]} + {1'b0, lfsrPrev[3:0]};
  endtask

  initial begin
    vectorCount  = 0;
    missCount    = 0;
    rst          = 1'b1;
    Logged_In    = 1'b0;
    Start        = 1'b0;
    Answer_Enter = 1'b0;
    Answer       = 5'd0;
    expSum       = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkAllZero("reset");

    // Start without a login is ignored.
    applyStimulus(1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 20; i++) begin
      checkOutput("nologin_qv", 16'(Question_Valid), 16'd0);
      tick();
    end
    checkOutput("nologin_round", 16'(Round), 16'd0);

    // Game 1: correct, wrong, correct.
    Logged_In = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd0);
    checkOutput("load_qv", 16'(Question_Valid), 16'd0);
    tick();
    checkOutput("g1r1_qv", 16'(Question_Valid), 16'd1);
    checkOutput("g1r1_round", 16'(Round), 16'd1);
    checkOperands("g1r1");
    applyStimulus(1'b0, 1'b1, expSum);
    checkOutput("g1r1_cor", 16'(Correct), 16'd1);
    checkOutput("g1r1_wr", 16'(Wrong), 16'd0);
    checkOutput("g1r1_to", 16'(Timeout), 16'd0);
    checkOutput("g1r1_score", 16'(Score), 16'd1);
    checkOutput("g1r1_resqv", 16'(Question_Valid), 16'd0);
    tick();
    checkOutput("g1r1_corend", 16'(Correct), 16'd0);
    checkOutput("g1_loadqv", 16'(Question_Valid), 16'd0);
    tick();
    checkOutput("g1r2_qv", 16'(Question_Valid), 16'd1);
    checkOutput("g1r2_round", 16'(Round), 16'd2);
    checkOperands("g1r2");
    applyStimulus(1'b0, 1'b1, expSum + 5'd1);
    checkOutput("g1r2_wr", 16'(Wrong), 16'd1);
    checkOutput("g1r2_cor", 16'(Correct), 16'd0);
    checkOutput("g1r2_score", 16'(Score), 16'd1);
    tick();
    tick();
    checkOutput("g1r3_qv", 16'(Question_Valid), 16'd1);
    checkOutput("g1r3_round", 16'(Round), 16'd3);
    checkOperands("g1r3");
    applyStimulus(1'b0, 1'b1, expSum);
    checkOutput("g1r3_cor", 16'(Correct), 16'd1);
    checkOutput("g1r3_score", 16'(Score), 16'd2);
    checkOutput("g1r3_go_early", 16'(Game_Over), 16'd0);
    tick();
    checkOutput("g1_go", 16'(Game_Over), 16'd1);
    checkOutput("g1_score", 16'(Score), 16'd2);
    checkOutput("g1_round", 16'(Round), 16'd3);
    checkOutput("g1_doneqv", 16'(Question_Valid), 16'd0);
    applyStimulus(1'b0, 1'b1, expSum);
    checkOutput("done_ignore_cor", 16'(Correct), 16'd0);
    checkOutput("done_hold_go", 16'(Game_Over), 16'd1);
    checkOutput("done_hold_score", 16'(Score), 16'd2);

    // Game 2: restart from DONE, timeout round, then logout with an answer.
    applyStimulus(1'b1, 1'b0, 5'd0);
    checkOutput("g2_load_score", 16'(Score), 16'd0);
    checkOutput("g2_load_go", 16'(Game_Over), 16'd0);
    tick();
    checkOutput("g2r1_round", 16'(Round), 16'd1);
    checkOperands("g2r1");
    askCycles = 0;
    while (Question_Valid && askCycles < 50) begin
      askCycles++;
      tick();
    end
    checkOutput("g2r1_askcycles", 16'(askCycles), 16'd10);
    checkOutput("g2r1_to", 16'(Timeout), 16'd1);
    checkOutput("g2r1_cor", 16'(Correct), 16'd0);
    checkOutput("g2r1_score", 16'(Score), 16'd0);
    tick();
    checkOutput("g2r1_toend", 16'(Timeout), 16'd0);
    tick();
    checkOutput("g2r2_qv", 16'(Question_Valid), 16'd1);
    checkOutput("g2r2_round", 16'(Round), 16'd2);
    checkOperands("g2r2");
    Logged_In = 1'b0;
    applyStimulus(1'b0, 1'b1, expSum);
    checkOutput("logout_cor", 16'(Correct), 16'd0);
    checkOutput("logout_qv", 16'(Question_Valid), 16'd0);
    checkOutput("logout_score", 16'(Score), 16'd0);
    checkOutput("logout_round", 16'(Round), 16'd2);
    checkOutput("logout_go", 16'(Game_Over), 16'd0);
    Logged_In = 1'b1;
    tick();
    checkOutput("logout_idle_cor", 16'(Correct), 16'd0);
    checkOutput("logout_idle_qv", 16'(Question_Valid), 16'd0);

    // Game 3: answer on the last allowed ASK cycle, then reset mid-ASK.
    applyStimulus(1'b1, 1'b0, 5'd0);
    tick();
    checkOutput("g3r1_round", 16'(Round), 16'd1);
    checkOperands("g3r1");
    repeat (9) tick();
    checkOutput("g3r1_lastqv", 16'(Question_Valid), 16'd1);
    applyStimulus(1'b0, 1'b1, expSum);
    checkOutput("g3r1_cor", 16'(Correct), 16'd1);
    checkOutput("g3r1_to", 16'(Timeout), 16'd0);
    checkOutput("g3r1_score", 16'(Score), 16'd1);
    tick();
    checkOutput("g3r1_to_after", 16'(Timeout), 16'd0);
    tick();
    checkOutput("g3r2_qv", 16'(Question_Valid), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkAllZero("midrst");

    // LFSR sequence from the seed, including that it never reaches zero.
    for (int i = 0; i < 255; i++) begin
      checkOutput("lfsr_seq", 16'(dut.lfsr_q), 16'(lfsrModel));
      checkOutput("lfsr_nz", 16'(dut.lfsr_q != 8'd0), 16'd1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
